// File: rtl/param_bus_interface.sv
// Edge-triggered producer/consumer buffer: DATA_W-bit words in a DEPTH-entry
// circular FIFO with occupancy flags and an overflow/underflow error flag.
module param_bus_interface #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dataReady,
    input  logic [DATA_W-1:0]        inBus,
    input  logic                     receiveData,
    input  logic                     errClr,
    output logic [DATA_W-1:0]        outBus,
    output logic                     readyToAccept,
    output logic                     OutBuffFull,
    output logic                     bufEmpty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic              dr_q,      dr_d;
    logic              rcv_q,     rcv_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [DATA_W-1:0] out_q,     out_d;
    logic              err_q,     err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic wr, rd, full, empty, wr_en, rd_en, fault;

    always_comb begin
        wr    = dataReady & ~dr_q;
        rd    = receiveData & ~rcv_q;
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);

        // A read in the same cycle frees the slot a full-buffer write needs.
        wr_en = wr & (~full | rd);
        rd_en = rd & ~empty;
        fault = (wr & full & ~rd) | (rd & empty);

        dr_d     = dataReady;
        rcv_d    = receiveData;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        out_d    = out_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            out_d    = mem_q[rd_ptr_q];
        end

        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

        if (ERR_STICKY) begin
            if (fault) begin
                err_d = 1'b1;
            end else if (errClr) begin
                err_d = 1'b0;
            end else begin
                err_d = err_q;
            end
        end else begin
            err_d = fault;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_q     <= 1'b0;
            rcv_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            dr_q     <= dr_d;
            rcv_q    <= rcv_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    // Storage carries no reset; contents are only observable after a write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= inBus;
        end
    end

    assign outBus        = out_q;
    assign count         = count_q;
    assign error         = err_q;
    assign readyToAccept = (count_q != FULL_CNT);
    assign OutBuffFull   = (count_q == FULL_CNT);
    assign bufEmpty      = (count_q == '0);

endmodule

// File: doc/param_bus_interface.md
# param_bus_interface

Parametrised successor to the 8-bit bus interface. It accepts DATA_W-bit words on a level-held `dataReady` strobe and buffers them in a DEPTH-entry circular FIFO. It delivers words in arrival order on a `receiveData` strobe and flags overflow or underflow. The block sits between a producer bus and a consumer that pulls words at its own rate.

## Interface
Parameters:
- DATA_W, 8, word width in bits (≥1)
- DEPTH, 4, buffer entries; power of two, ≥2
- ERR_STICKY, 1, 1: `error` holds until `errClr` or reset; 0: `error` is a one-cycle pulse per fault

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- dataReady  in  1  producer strobe, level; may be held several cycles
- inBus  in  DATA_W  producer word, sampled on the `dataReady` rising edge
- receiveData  in  1  consumer strobe, level; may be held several cycles
- errClr  in  1  synchronous clear of sticky `error`
- outBus  out  DATA_W  last word delivered (registered)
- readyToAccept  out  1  buffer not full
- OutBuffFull  out  1  buffer holds DEPTH words
- bufEmpty  out  1  buffer holds 0 words
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- error  out  1  overflow/underflow flag

## Operation
- Edge detect:
  - `dataReady` and `receiveData` are each registered once; prev registers reset to 0.
  - wr = dataReady & ~dataReady_q; rd = receiveData & ~receiveData_q.
  - A strobe held N cycles produces exactly one transfer. A strobe already high at the first clock after reset counts as one edge.
- Storage: DEPTH×DATA_W array with wr_ptr and rd_ptr of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH naturally. `count` is tracked explicitly.
- All decisions use the pre-edge full/empty state:
  - wr & !full: mem[wr_ptr] <= inBus; wr_ptr++.
  - wr & full: word dropped; overflow fault.
  - rd & !empty: outBus <= mem[rd_ptr]; rd_ptr++.
  - rd & empty: outBus unchanged; underflow fault.
  - wr & rd, neither full nor empty: both occur; count unchanged.
  - wr & rd when full: both occur (read frees the slot); count stays DEPTH; no fault.
  - wr & rd when empty: write accepted; read is underflow (no bypass); count becomes 1.
- Error:
  - ERR_STICKY=1: any fault sets `error`, and it holds. `errClr` clears it on the next edge. A fault in the same cycle as `errClr` wins (error stays 1).
  - ERR_STICKY=0: `error` = 1 for exactly the cycle after a fault; `errClr` is ignored.
- Flags: readyToAccept = (count != DEPTH); OutBuffFull = (count == DEPTH); bufEmpty = (count == 0). All are combinational from registered `count`.

## Timing
- Reset, asynchronous and immediate: count=0, pointers=0, outBus=0, error=0, edge registers=0. As a result readyToAccept=1, OutBuffFull=0, bufEmpty=1. Memory contents are don't-care.
- Write latency: `dataReady` rising at sampling edge k. At edge k, count increments. Flags reflect the new count after edge k.
- Read latency: rd seen at edge k; outBus is valid after edge k (1 cycle) and holds until the next successful read.
- Throughput: one write and one read per two cycles per strobe (edge detect needs a low cycle between transfers).
- Reset mid-operation: buffered words are lost. outBus returns to 0 at once. A strobe held across reset release counts as a new edge.

## Test plan
- Reset, then write 52, 0, 5, 0, with the first `dataReady` held 2 cycles and the rest 1 cycle -> count=4, OutBuffFull=1, readyToAccept=0, error=0. The held strobe is counted once.
- With the buffer full, write 8'hAA -> word dropped, count=4, error=1 and staying 1 (ERR_STICKY=1). Assert errClr for 1 cycle -> error=0.
- Four `receiveData` pulses -> outBus successively 52, 0, 5, 0, each valid 1 cycle after its strobe edge. bufEmpty=1 after the fourth.
- Fifth `receiveData` on the empty buffer -> outBus stays 0, error=1. With ERR_STICKY=0, error is high for exactly 1 cycle.
- Simultaneous wr/rd edges: with count=4, both strobes -> count=4, no error, oldest word out. With count=0 and inBus=7 -> count=1, error=1, and a later read returns 7.
- Fill across the wrap point (DEPTH=4: 6 writes interleaved with reads) -> order preserved. Assert rst mid-stream -> all outputs return to their reset values immediately.
